// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-width encodings, register index
// width, the MEM/WB bundle and the load lane/extension helpers.
package mips_pkg;

  localparam int NB_REG = 5;

  // Access size encodings shared with decode/execute; 2'b10 behaves as a word.
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  // MEM/WB pipeline register contents. lane/width/is_unsigned are kept so the
  // synchronously read word can be steered and extended after the edge.
  typedef struct packed {
    logic              mem2reg;
    logic              reg_write;
    logic [NB_REG-1:0] write_reg;
    logic [31:0]       alu_result;
    logic              misaligned;
    logic              load;
    logic [1:0]        lane;
    logic [1:0]        width;
    logic              is_unsigned;
  } mem_wb_t;

  // Half needs addr[0]=0, word (incl. 2'b10) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] lo,
                                         input logic       access);
    return access & (((width == WIDTH_HALF) & lo[0]) | (width[1] & (lo != 2'b00)));
  endfunction

  // Shift the addressed byte/half down to bit 0 and sign/zero extend.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  width,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (width)
      WIDTH_BYTE: load_extend = {{24{b[7] & ~uns}}, b};
      WIDTH_HALF: load_extend = {{16{h[15] & ~uns}}, h};
      default:    load_extend = w;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-lane-enabled synchronous data RAM: one read/write port (read-before-
// write) plus a read-only debug port. The array itself is never reset.
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [3:0]         i_we,
  input  logic [NB_ADDR-3:0] i_addr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-3:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_rdata,
  output logic [NB_DATA-1:0] o_dbg_data
);

  localparam int WORDS = 2 ** (NB_ADDR - 2);

  logic [NB_DATA/8-1:0][7:0] mem [WORDS];
  logic [NB_DATA-1:0]        rdata_d, rdata_q;
  logic [NB_DATA-1:0]        dbg_d, dbg_q;

  // Lane writes; an edge seen while reset is held never commits.
  always_ff @(posedge clk) begin
    if (i_rst_n) begin
      for (int l = 0; l < NB_DATA/8; l++) begin
        if (i_we[l]) mem[i_addr][l] <= i_wdata[8*l +: 8];
      end
    end
  end

  // Read port holds while the stage is frozen; debug port always follows.
  always_comb begin
    rdata_d = i_en ? mem[i_addr] : rdata_q;
    dbg_d   = mem[i_dbg_addr];
  end

  // Read registers sample the pre-write contents of the array.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
      dbg_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      dbg_q   <= dbg_d;
    end
  end

  assign o_rdata    = rdata_q;
  assign o_dbg_data = dbg_q;

endmodule

// File: rtl/memory_access.sv
// MEM stage: lane steering for stores, misalignment check, MEM/WB register
// and post-register load extension of the synchronously read word.
module memory_access
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data2mem,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_mem2reg,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_unsigned,
  input  logic [NB_REG-1:0]  i_write_reg,
  input  logic [NB_ADDR-3:0] i_dbg_addr,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_read_data,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_dbg_data
);

  logic [NB_ADDR-1:0] addr;
  logic               frozen;
  logic               mis;
  logic [3:0]         lanes;
  logic [3:0]         we;
  logic [NB_DATA-1:0] wdata;
  logic [NB_DATA-1:0] ram_rdata;
  mem_wb_t            mwb_d, mwb_q;

  assign addr = i_result[NB_ADDR-1:0];

  // Access decode: misalignment, lane enables and replicated store data.
  always_comb begin
    frozen = i_stall | i_halt;
    mis    = is_misaligned(i_width, addr[1:0], i_memRead | i_memWrite);
    case (i_width)
      WIDTH_BYTE: begin
        lanes = 4'b0001 << addr[1:0];
        wdata = {4{i_data2mem[7:0]}};
      end
      WIDTH_HALF: begin
        lanes = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_data2mem[15:0]}};
      end
      default: begin
        lanes = 4'b1111;
        wdata = i_data2mem;
      end
    endcase
    we = (i_memWrite && !mis && !frozen) ? lanes : 4'b0000;
  end

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_dmem (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_en       (!frozen),
    .i_we       (we),
    .i_addr     (addr[NB_ADDR-1:2]),
    .i_wdata    (wdata),
    .i_dbg_addr (i_dbg_addr),
    .o_rdata    (ram_rdata),
    .o_dbg_data (o_dbg_data)
  );

  // Next MEM/WB bundle; a frozen stage keeps the previous one.
  always_comb begin
    mwb_d = mwb_q;
    if (!frozen) begin
      mwb_d.mem2reg     = i_mem2reg;
      mwb_d.reg_write   = i_regWrite & ~mis;
      mwb_d.write_reg   = i_write_reg;
      mwb_d.alu_result  = i_result;
      mwb_d.misaligned  = mis;
      mwb_d.load        = i_memRead & ~mis;
      mwb_d.lane        = addr[1:0];
      mwb_d.width       = i_width;
      mwb_d.is_unsigned = i_unsigned;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) mwb_q <= '0;
    else          mwb_q <= mwb_d;
  end

  assign o_mem2reg    = mwb_q.mem2reg;
  assign o_regWrite   = mwb_q.reg_write;
  assign o_write_reg  = mwb_q.write_reg;
  assign o_alu_result = mwb_q.alu_result;
  assign o_misaligned = mwb_q.misaligned;
  assign o_read_data  = mwb_q.load ?
                        load_extend(ram_rdata, mwb_q.lane, mwb_q.width, mwb_q.is_unsigned) : '0;

endmodule
